tcp_server: RTL

Passive-open TCP server controller: the responder end of the connection opened by the team's TCP client controller, using the same 224-bit single-word packet format. It sits behind the packet ingress as one server endpoint. It performs the three-way handshake, acknowledges in-order 32-bit data segments, and runs the passive close. Its replies leave through a valid/ready output channel.

---
 rtl/tcp_server.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/tcp_server.sv
// Passive-open TCP server: three-way handshake, in-order 32-bit data ACKs and passive close
// over a 224-bit single-word packet. Optional handshake/close timeout under TCP_SERVER_TIMEOUT_EN.
module tcp_server #(
    parameter logic [15:0] LOCAL_PORT     = 16'd80,
    parameter logic [31:0] ISN            = 32'h0000_1000,
    parameter logic [15:0] WINDOW         = 16'd1024,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [223:0] packet_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [223:0] packet_out,
    output logic         rx_valid,
    output logic [31:0]  rx_data,
    output logic [2:0]   state_out,
    output logic         connected
);

    typedef enum logic [2:0] {
        ST_LISTEN      = 3'd0,
        ST_SYN_RCVD    = 3'd1,
        ST_ESTABLISHED = 3'd2,
        ST_CLOSE_WAIT  = 3'd3,
        ST_LAST_ACK    = 3'd4
    } state_t;

    localparam logic [5:0] FL_FIN = 6'b000001;
    localparam logic [5:0] FL_SYN = 6'b000010;
    localparam logic [5:0] FL_RST = 6'b000100;
    localparam logic [5:0] FL_ACK = 6'b010000;

    state_t         state_q, state_d;
    logic           out_valid_q, out_valid_d;
    logic [223:0]   packet_out_q, packet_out_d;
    logic           rx_valid_q, rx_valid_d;
    logic [31:0]    rx_data_q, rx_data_d;
    logic [15:0]    peer_port_q, peer_port_d;
    logic [31:0]    rcv_nxt_q, rcv_nxt_d;
    logic [31:0]    snd_nxt_q, snd_nxt_d;
    logic           go_listen;
    logic [31:0]    rcv_adv;

`ifdef TCP_SERVER_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0]    timer_q, timer_d;
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif

    // Received packet fields
    logic [15:0] in_dst, in_src;
    logic [31:0] in_seq, in_ack, in_data;
    logic        f_fin, f_syn, f_rst, f_psh, f_ack;
    logic        pkt_ok;
    logic        unused_bits;

    assign in_dst  = packet_in[15:0];
    assign in_src  = packet_in[31:16];
    assign in_seq  = packet_in[63:32];
    assign in_ack  = packet_in[95:64];
    assign f_fin   = packet_in[112];
    assign f_syn   = packet_in[113];
    assign f_rst   = packet_in[114];
    assign f_psh   = packet_in[115];
    assign f_ack   = packet_in[116];
    assign in_data = packet_in[223:192];
    assign unused_bits = ^{packet_in[111:96], packet_in[191:117]};

    // Nothing is accepted while a reply is still waiting in the output slot.
    assign pkt_ok = in_valid && !out_valid_q && (in_dst == LOCAL_PORT) &&
                    ((state_q == ST_LISTEN) || (in_src == peer_port_q));

    function automatic logic [223:0] build_reply(input logic [5:0] flags, input logic [31:0] seq,
                                                 input logic [31:0] ack, input logic [15:0] dest);
        logic [223:0] p;
        p          = '0;
        p[15:0]    = dest;
        p[31:16]   = LOCAL_PORT;
        p[63:32]   = seq;
        p[95:64]   = ack;
        p[111:96]  = WINDOW;
        p[117:112] = flags;
        p[127:124] = 4'd5;
        return p;
    endfunction

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state_q      <= ST_LISTEN;
            out_valid_q  <= 1'b0;
            packet_out_q <= '0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= '0;
            peer_port_q  <= '0;
            rcv_nxt_q    <= '0;
            snd_nxt_q    <= '0;
`ifdef TCP_SERVER_TIMEOUT_EN
            timer_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            packet_out_q <= packet_out_d;
            rx_valid_q   <= rx_valid_d;
            rx_data_q    <= rx_data_d;
            peer_port_q  <= peer_port_d;
            rcv_nxt_q    <= rcv_nxt_d;
            snd_nxt_q    <= snd_nxt_d;
`ifdef TCP_SERVER_TIMEOUT_EN
            timer_q      <= timer_d;
`endif
        end
    end

    always_comb begin : next_state_comb
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        packet_out_d = packet_out_q;
        rx_valid_d   = 1'b0;
        rx_data_d    = rx_data_q;
        peer_port_d  = peer_port_q;
        rcv_nxt_d    = rcv_nxt_q;
        snd_nxt_d    = snd_nxt_q;
        go_listen    = 1'b0;
        rcv_adv      = rcv_nxt_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (state_q == ST_CLOSE_WAIT) begin
            if (!out_valid_q) begin
                out_valid_d  = 1'b1;
                packet_out_d = build_reply(FL_FIN | FL_ACK, snd_nxt_q, rcv_nxt_q, peer_port_q);
                snd_nxt_d    = snd_nxt_q + 32'd1;
                state_d      = ST_LAST_ACK;
            end
        end else if (pkt_ok) begin
            if (f_rst) begin
                go_listen = (state_q != ST_LISTEN);
            end else begin
                case (state_q)
                    ST_LISTEN: begin
                        if (f_syn && !f_ack) begin
                            peer_port_d  = in_src;
                            rcv_nxt_d    = in_seq + 32'd1;
                            snd_nxt_d    = ISN + 32'd1;
                            out_valid_d  = 1'b1;
                            packet_out_d = build_reply(FL_SYN | FL_ACK, ISN, in_seq + 32'd1, in_src);
                            state_d      = ST_SYN_RCVD;
                        end
                    end
                    ST_SYN_RCVD: begin
                        if (f_ack && (in_ack == snd_nxt_q)) begin
                            state_d = ST_ESTABLISHED;
                        end else if (f_ack) begin
                            out_valid_d  = 1'b1;
                            packet_out_d = build_reply(FL_RST, in_ack, 32'd0, peer_port_q);
                            go_listen    = 1'b1;
                        end else if (f_syn && (in_seq + 32'd1 == rcv_nxt_q)) begin
                            out_valid_d  = 1'b1;
                            packet_out_d = build_reply(FL_SYN | FL_ACK, ISN, rcv_nxt_q, peer_port_q);
                        end
                    end
                    ST_ESTABLISHED: begin
                        // A PSH+FIN segment consumes its 4 data bytes plus one for the FIN.
                        if (f_psh && (in_seq == rcv_nxt_q)) begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = in_data;
                            rcv_adv    = rcv_nxt_q + (f_fin ? 32'd5 : 32'd4);
                            if (f_fin) begin
                                state_d = ST_CLOSE_WAIT;
                            end
                        end else if (!f_psh && f_fin) begin
                            rcv_adv = rcv_nxt_q + 32'd1;
                            state_d = ST_CLOSE_WAIT;
                        end
                        if (f_psh || f_fin) begin
                            rcv_nxt_d    = rcv_adv;
                            out_valid_d  = 1'b1;
                            packet_out_d = build_reply(FL_ACK, snd_nxt_q, rcv_adv, peer_port_q);
                        end
                    end
                    ST_LAST_ACK: begin
                        if (f_ack && (in_ack == snd_nxt_q)) begin
                            go_listen = 1'b1;
                        end else if (f_fin) begin
                            out_valid_d  = 1'b1;
                            packet_out_d = build_reply(FL_FIN | FL_ACK, snd_nxt_q - 32'd1,
                                                       rcv_nxt_q, peer_port_q);
                        end
                    end
                    default: go_listen = 1'b1;
                endcase
            end
        end

`ifdef TCP_SERVER_TIMEOUT_EN
        timer_d = timer_q;
        if (state_q == ST_SYN_RCVD || state_q == ST_LAST_ACK) begin
            if (pkt_ok) begin
                timer_d = '0;
            end else if (timer_q == TIMEOUT_LAST) begin
                go_listen = 1'b1;
            end else begin
                timer_d = timer_q + 32'd1;
            end
        end
`endif

        if (go_listen) begin
            state_d     = ST_LISTEN;
            peer_port_d = '0;
            rcv_nxt_d   = '0;
            snd_nxt_d   = '0;
        end

`ifdef TCP_SERVER_TIMEOUT_EN
        // Any state change restarts the count, so entering a waiting state starts from zero.
        if (state_d != state_q) begin
            timer_d = '0;
        end
`endif
    end

    always_comb begin : output_comb
        out_valid  = out_valid_q;
        packet_out = packet_out_q;
        rx_valid   = rx_valid_q;
        rx_data    = rx_data_q;
        state_out  = state_q;
        connected  = (state_q == ST_ESTABLISHED);
    end

endmodule
